// File: rtl/bridge.sv
// bridge: CPU-to-timer address decode, write steering, read mux and registered HW interrupt vector
module bridge #(
  parameter logic [31:0] TIMER0_BASE = 32'h0000_7F00,
  parameter logic [31:0] TIMER1_BASE = 32'h0000_7F10,
  parameter int          TIMER_SPAN  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] path_addr,
  input  logic [31:0] path_data,
  input  logic        path_we,
  input  logic [31:0] timer0_dout,
  input  logic [31:0] timer1_dout,
  input  logic        IRQ0,
  input  logic        IRQ1,
  input  logic        interrupt,
  output logic [7:2]  HW,
  output logic [31:0] PR_RD,
  output logic [31:0] timer_addr,
  output logic [31:0] timer_din,
  output logic        timer0_we,
  output logic        timer1_we
);
  localparam logic [31:0] TIMER0_LAST = TIMER0_BASE + 32'(TIMER_SPAN - 1);
  localparam logic [31:0] TIMER1_LAST = TIMER1_BASE + 32'(TIMER_SPAN - 1);
  logic hit0, hit1;
  // full-width window decode, write steering gated by reset, and read-back mux
  always_comb begin
    hit0 = path_addr >= TIMER0_BASE && path_addr <= TIMER0_LAST;
    hit1 = path_addr >= TIMER1_BASE && path_addr <= TIMER1_LAST;
    timer_addr = path_addr;
    timer_din = path_data;
    timer0_we = path_we & hit0 & ~reset;
    timer1_we = path_we & hit1 & ~reset;
    PR_RD = hit0 ? timer0_dout : hit1 ? timer1_dout : 32'h0;
  end
  // sample interrupt levels once per edge; cleared while reset is high
  always_ff @(posedge clk)
    HW <= reset ? 6'b0 : {3'b000, interrupt, IRQ1, IRQ0};
endmodule

// File: tb/tb_bridge.sv
// tb_bridge: table-driven combinational checks plus directed HW interrupt and reset sequences
module tb_bridge;
  logic        clk = 0;
  logic        reset;
  logic [31:0] path_addr, path_data, timer0_dout, timer1_dout;
  logic        path_we, IRQ0, IRQ1, interrupt;
  logic [7:2]  HW;
  logic [31:0] PR_RD, timer_addr, timer_din;
  logic        timer0_we, timer1_we;
  int checks = 0;
  int errors = 0;
  bridge dut (
    .clk(clk), .reset(reset), .path_addr(path_addr), .path_data(path_data),
    .path_we(path_we), .timer0_dout(timer0_dout), .timer1_dout(timer1_dout),
    .IRQ0(IRQ0), .IRQ1(IRQ1), .interrupt(interrupt), .HW(HW), .PR_RD(PR_RD),
    .timer_addr(timer_addr), .timer_din(timer_din),
    .timer0_we(timer0_we), .timer1_we(timer1_we)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic        we0;
    logic        we1;
    logic [31:0] rd;
  } vec_t;
  localparam logic [31:0] D0 = 32'hAAAA_5555;
  localparam logic [31:0] D1 = 32'h1234_5678;
  vec_t vecs [13];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic tick_check(input string n, input logic [5:0] e);
    @(posedge clk);
    #1 chk(n, 32'(HW), 32'(e));
    @(negedge clk);
  endtask
  initial begin
    vecs = '{
      '{32'h0000_7F04, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, D0},
      '{32'h0000_7F18, 32'h0000_0001, 1'b0, 1'b0, 1'b0, D1},
      '{32'h0000_7EFF, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 32'h0},
      '{32'h0000_7F0C, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 32'h0},
      '{32'h0000_7F1C, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0},
      '{32'h0001_7F00, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 32'h0},
      '{32'h0000_7F0B, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, D0},
      '{32'h0000_7F10, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b1, D1},
      '{32'h0000_7F0F, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 32'h0},
      '{32'h0000_7F1B, 32'h5A5A_A5A5, 1'b1, 1'b0, 1'b1, D1},
      '{32'h0000_7F00, 32'h0000_0007, 1'b0, 1'b0, 1'b0, D0},
      '{32'h0000_7F03, 32'h1111_2222, 1'b1, 1'b1, 1'b0, D0},
      '{32'hFFFF_7F04, 32'h3333_4444, 1'b1, 1'b0, 1'b0, 32'h0}
    };
    reset = 1; path_addr = 0; path_data = 0; path_we = 0;
    timer0_dout = D0; timer1_dout = D1;
    IRQ0 = 1; IRQ1 = 1; interrupt = 1;
    @(negedge clk);
    tick_check("hw_reset", 6'b000000);
    reset = 0;
    tick_check("hw_release", 6'b000111);
    for (int i = 0; i < 13; i++) begin
      path_addr = vecs[i].addr;
      path_data = vecs[i].data;
      path_we = vecs[i].we;
      #1;
      chk($sformatf("v%0d_we0", i), 32'(timer0_we), 32'(vecs[i].we0));
      chk($sformatf("v%0d_we1", i), 32'(timer1_we), 32'(vecs[i].we1));
      chk($sformatf("v%0d_rd", i), PR_RD, vecs[i].rd);
      chk($sformatf("v%0d_addr", i), timer_addr, vecs[i].addr);
      chk($sformatf("v%0d_din", i), timer_din, vecs[i].data);
    end
    @(negedge clk);
    path_we = 0; IRQ0 = 0; IRQ1 = 0; interrupt = 0;
    tick_check("hw_idle", 6'b000000);
    IRQ1 = 1;
    tick_check("hw_irq1_on", 6'b000010);
    IRQ1 = 0;
    tick_check("hw_irq1_off", 6'b000000);
    interrupt = 1;
    tick_check("hw_ext", 6'b000100);
    IRQ0 = 1;
    tick_check("hw_multi", 6'b000101);
    IRQ0 = 0; interrupt = 0;
    tick_check("hw_clear", 6'b000000);
    #2 IRQ0 = 1;
    #2 IRQ0 = 0;
    tick_check("hw_glitch", 6'b000000);
    reset = 1; path_addr = 32'h0000_7F00; path_we = 1; IRQ1 = 1;
    #1;
    chk("rst_we0", 32'(timer0_we), 32'h0);
    chk("rst_rd", PR_RD, D0);
    tick_check("hw_in_reset", 6'b000000);
    reset = 0;
    #1 chk("rel_we0", 32'(timer0_we), 32'h1);
    chk("rel_we1", 32'(timer1_we), 32'h0);
    tick_check("hw_after_rst", 6'b000010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bridge.md
Name: bridge

Overview:
- System bridge between the MIPS CPU datapath and the two memory-mapped timer peripherals in the P7 system.
- Decodes the CPU data address and steers write enables to the selected timer. Multiplexes timer read data back to the CPU.
- Collects the peripheral interrupt lines into the 6-bit HW interrupt vector used by CP0.

Parameters:
TIMER0_BASE, 32'h0000_7F00, base byte address of timer0 register window
TIMER1_BASE, 32'h0000_7F10, base byte address of timer1 register window
TIMER_SPAN, 12, window size in bytes per timer (three 32-bit registers)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
path_addr  input  32  CPU data byte address
path_data  input  32  CPU store data
path_we  input  1  CPU store strobe (device-space write)
timer0_dout  input  32  timer0 read data for timer_addr
timer1_dout  input  32  timer1 read data for timer_addr
IRQ0  input  1  timer0 interrupt request
IRQ1  input  1  timer1 interrupt request
interrupt  input  1  external interrupt source
HW  output  6 (bits 7:2)  hardware interrupt vector to CP0
PR_RD  output  32  peripheral read data to CPU
timer_addr  output  32  address forwarded to both timers
timer_din  output  32  write data forwarded to both timers
timer0_we  output  1  timer0 write enable
timer1_we  output  1  timer1 write enable

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high.
- Decode is combinational on the full 32-bit address:
  - hit0 = TIMER0_BASE <= path_addr <= TIMER0_BASE+TIMER_SPAN-1.
  - hit1 = TIMER1_BASE <= path_addr <= TIMER1_BASE+TIMER_SPAN-1.
  - Windows never overlap. Low two address bits do not affect decode inside a window.
- timer_addr = path_addr, combinational pass-through, unaffected by reset.
- timer_din = path_data, combinational pass-through, unaffected by reset.
- Write enables: timer0_we = path_we & hit0 & ~reset; timer1_we = path_we & hit1 & ~reset.
  - At most one enable is high in any cycle.
  - An unmapped address produces no write enable.
- PR_RD, combinational:
  - timer0_dout when hit0.
  - timer1_dout when hit1.
  - 32'h0000_0000 otherwise, including unmapped addresses.
  - Independent of path_we.
- HW is registered, one-cycle latency:
  - Each rising clk: HW <= {3'b000, interrupt, IRQ1, IRQ0}, i.e. HW[2]=IRQ0, HW[3]=IRQ1, HW[4]=interrupt, HW[7:5]=0.
  - Reset: HW <= 6'b0 on the reset edge; held 0 while reset is high.
  - Levels are sampled, not latched: a request dropped before a clk edge is not seen.
  - Simultaneous requests all appear in the same HW value.
- Reset mid-operation: a write in progress while reset is asserted is suppressed. Read mux is unaffected.
- Boundary addresses:
  - 0x7F0B hits timer0; 0x7F0C and 0x7EFF miss.
  - 0x7F1B hits timer1; 0x7F1C and 0x7F0F miss.
  - Upper address bits must match: 0x0001_7F00 misses.

Test Plan:
- Reset: reset=1 one cycle with IRQ0=IRQ1=interrupt=1 -> HW=6'b0. Release reset -> next edge HW=6'b000111.
- Timer0 write: path_addr=0x7F04, path_data=0xDEADBEEF, path_we=1 -> timer0_we=1, timer1_we=0, timer_addr=0x7F04, timer_din=0xDEADBEEF.
- Timer1 read: path_addr=0x7F18, timer1_dout=0x12345678, timer0_dout=0xAAAA5555, path_we=0 -> PR_RD=0x12345678, both we=0.
- Boundaries: path_addr in {0x7EFF, 0x7F0C, 0x7F1C, 0x0001_7F00} with path_we=1 -> both we=0, PR_RD=0. 0x7F0B -> timer0_we=1. 0x7F10 -> timer1_we=1.
- Interrupt latency: IRQ1 pulses high for one cycle -> HW[3]=1 exactly the cycle after, then 0. interrupt=1 alone -> HW=6'b000100 after one edge.
- Write during reset: reset=1, path_addr=0x7F00, path_we=1 -> timer0_we=0. Deassert reset -> timer0_we=1 combinationally.
